adder_operand_queue: RTL and testbench

- Buffers operand pairs ahead of adder_top and presents one pair at a time on data_A/data_B.
- Producers push pairs through a valid/ready handshake; the consumer side pops them through its own valid/ready handshake.
- First-word-fall-through FIFO: the head pair is always driven straight onto the adder inputs, so the registered-result stage downstream sees a stable pair for as long as out_valid is held.

---
 rtl/adder_operand_queue.sv | 65 ++++++
 tb/tb_adder_operand_queue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/adder_operand_queue.sv
// adder_operand_queue: first-word-fall-through FIFO of operand pairs feeding adder_top.
module adder_operand_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_A,
  input  logic [WIDTH:0]   in_B,
  output logic [WIDTH:0]   data_A,
  output logic [WIDTH:0]   data_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH:0]   mem_a_q [DEPTH];
  logic [WIDTH:0]   mem_b_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  assign full      = count_q == CNT_W'(DEPTH);
  assign empty     = count_q == '0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Empty queue drives zeros so the adder never sees a stale pair.
  assign data_A    = out_valid ? mem_a_q[rd_ptr_q] : '0;
  assign data_B    = out_valid ? mem_b_q[rd_ptr_q] : '0;
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | (in_valid & ~in_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_a_q[wr_ptr_q] <= in_A;
      mem_b_q[wr_ptr_q] <= in_B;
    end
  end
endmodule

// File: tb/tb_adder_operand_queue.sv
// tb_adder_operand_queue: directed scoreboard bench for the operand-pair FIFO.
module tb_adder_operand_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH:0]   in_A = '0;
  logic [WIDTH:0]   in_B = '0;
  logic [WIDTH:0]   data_A, data_B;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] count;
  logic             full, empty, overflow;
  int               checks = 0;
  int               errors = 0;
  logic [2*WIDTH+1:0] sb_q [$];
  logic             m_ovf = 1'b0;

  adder_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .data_A(data_A), .data_B(data_B),
    .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [WIDTH:0] ea, eb;
    ea = '0;
    eb = '0;
    if (sb_q.size() > 0) {ea, eb} = sb_q[0];
    chk({tag, ".count"}, 64'(count), 64'(sb_q.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(sb_q.size() == 0));
    chk({tag, ".full"}, 64'(full), 64'(sb_q.size() == DEPTH));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(sb_q.size() != DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb_q.size() != 0));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".data_A"}, 64'(data_A), 64'(ea));
    chk({tag, ".data_B"}, 64'(data_B), 64'(eb));
  endtask

  // Called at a negedge: drive one cycle, model it, advance to next negedge and check.
  task automatic cyc(input string tag, input logic v, input logic [WIDTH:0] a,
                     input logic [WIDTH:0] b, input logic r);
    logic was_full;
    was_full  = sb_q.size() == DEPTH;
    in_valid  = v;
    in_A      = a;
    in_B      = b;
    out_ready = r;
    if (r && sb_q.size() > 0) begin
      chk({tag, ".pop_A"}, 64'(data_A), 64'(sb_q[0][2*WIDTH+1:WIDTH+1]));
      chk({tag, ".pop_B"}, 64'(data_B), 64'(sb_q[0][WIDTH:0]));
      void'(sb_q.pop_front());
    end
    if (v && !was_full) sb_q.push_back({a, b});
    if (v && was_full) m_ovf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_rst(input string tag, input int n, input logic v);
    rst       = 1'b1;
    in_valid  = v;
    in_A      = 33'h1_dead_beef;
    in_B      = 33'h0_cafe_f00d;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    @(negedge clk);
    do_rst("reset", 2, 1'b0);
    cyc("idle", 1'b0, '0, '0, 1'b0);
    cyc("empty_pop", 1'b0, '0, '0, 1'b1);

    cyc("single_push", 1'b1, 33'h4234, 33'h5678, 1'b0);
    for (int i = 0; i < 5; i++) cyc("single_hold", 1'b0, '0, '0, 1'b0);
    cyc("single_pop", 1'b0, '0, '0, 1'b1);

    for (int i = 0; i <= DEPTH; i++) cyc("fill", 1'b1, 33'(i), 33'(32'h100 + i), 1'b0);
    cyc("full_pushpop", 1'b1, 33'h77, 33'h88, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, '0, '0, 1'b1);
    do_rst("reset_ovf", 1, 1'b0);

    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++)
        cyc("wrap_push", 1'b1, {1'b1, 32'(k * 3 + j)}, 33'(~(k * 3 + j)), 1'b0);
      for (int j = 0; j < 3; j++) cyc("wrap_pop", 1'b0, '0, '0, 1'b1);
    end

    cyc("sim_head", 1'b1, 33'd1, 33'd11, 1'b0);
    cyc("sim_pushpop", 1'b1, 33'd2, 33'd22, 1'b1);
    cyc("sim_drain", 1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 33'(40 + i), 33'(50 + i), 1'b0);
    do_rst("mid_reset", 1, 1'b1);
    cyc("post_rst", 1'b0, '0, '0, 1'b1);
    cyc("post_rst_push", 1'b1, 33'h1_0000_0001, 33'h0_ffff_ffff, 1'b0);
    cyc("post_rst_pop", 1'b0, '0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
